// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        StPllReset,
        StWaitLock,
        StStabilize,
        StRunning,
        StFault
    } sup_state_e;

    localparam int unsigned RelockCntW = 8;

    // Width needed to hold 0..n-1, never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock flag into the clk domain.
module pll_sup_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up / lock supervisor: pulses pll_rst, waits for a stable lock, releases system reset.
// Define PLL_SUP_RELOCK_COUNT_EN to build the saturating relock_count counter.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  clear_fault,
    output logic                  pll_rst,
    output logic                  sys_reset_n,
    output logic                  status_ok,
    output logic                  fault,
    output logic [RelockCntW-1:0] relock_count
);

    localparam int unsigned RstW    = cnt_w(PLL_RST_CYCLES);
    localparam int unsigned ToW     = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned StbW    = cnt_w(LOCK_STABLE_CYCLES);
    localparam int unsigned MaxAB   = (RstW > ToW) ? RstW : ToW;
    localparam int unsigned CntW    = (MaxAB > StbW) ? MaxAB : StbW;
    localparam int unsigned RetryW  = cnt_w(MAX_RETRIES + 1);

    logic              locked_s;
    sup_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              pll_rst_q, sys_reset_n_q, status_ok_q, fault_q;

    pll_sup_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        unique case (state_q)
            StPllReset: begin
                if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitLock: begin
                if (locked_s) begin
                    state_d = StStabilize;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    retry_d = retry_q + RetryW'(1);
                    state_d = (retry_d == RetryW'(MAX_RETRIES)) ? StFault : StPllReset;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStabilize: begin
                // A drop on the final stable cycle still sends us back to WAIT_LOCK.
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = StRunning;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRunning: begin
                if (!locked_s) begin
                    state_d = StPllReset;
                    cnt_d   = '0;
                end
            end
            StFault: begin
                if (clear_fault) begin
                    state_d = StPllReset;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StPllReset;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StPllReset;
            cnt_q         <= '0;
            retry_q       <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            status_ok_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rst_q     <= (state_d == StPllReset) || (state_d == StFault);
            sys_reset_n_q <= (state_d == StRunning);
            status_ok_q   <= (state_d == StRunning);
            fault_q       <= (state_d == StFault);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_reset_n_q;
    assign status_ok   = status_ok_q;
    assign fault       = fault_q;

`ifdef PLL_SUP_RELOCK_COUNT_EN
    logic [RelockCntW-1:0] relock_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            relock_q <= '0;
        end else if ((state_q == StRunning) && !locked_s && (relock_q != '1)) begin
            relock_q <= relock_q + RelockCntW'(1);
        end
    end

    assign relock_count = relock_q;
`else
    assign relock_count = '0;
`endif

endmodule
